awgn_urng_ctrl: RTL

Sequencer for the dual Tausworthe URNG pair that feeds the Box-Muller AWGN datapath. It holds six 32-bit seed registers written over a simple config port, validates them, and drives the URNG reset and seed load. It then runs a discard warm-up and streams (a,b) uniform pairs downstream through a 2-entry ready/valid buffer. The URNG advances only when buffer space exists, so backpressure never drops or repeats a sample.

---
 rtl/awgn_urng_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/awgn_urng_ctrl.sv
// awgn_urng_ctrl: seed store, load/warm-up sequencer and 2-entry output buffer
// for the dual Tausworthe URNG pair that feeds the Box-Muller AWGN datapath.
module awgn_urng_ctrl #(
  parameter int WARMUP = 16,
  parameter int W      = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_wr,
  input  logic [2:0]   cfg_addr,
  input  logic [W-1:0] cfg_wdata,
  input  logic         start,
  input  logic         stop,
  output logic         urng_rst,
  output logic         urng_en,
  output logic [W-1:0] urng_seed1,
  output logic [W-1:0] urng_seed2,
  output logic [W-1:0] urng_seed3,
  output logic [W-1:0] urng_seed4,
  output logic [W-1:0] urng_seed5,
  output logic [W-1:0] urng_seed6,
  input  logic [W-1:0] urng_a,
  input  logic [W-1:0] urng_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         busy,
  output logic         seed_err,
  output logic [31:0]  sample_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_t;

  state_t       state;
  logic [7:0]   warm_cnt;
  logic [W-1:0] fa [2];
  logic [W-1:0] fb [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   fifo_cnt;
  logic         seeds_ok, go, push, pop;

  // Each Tausworthe component needs its seed above a minimum or it degenerates
  assign seeds_ok = (urng_seed1 >= W'(2))  && (urng_seed4 >= W'(2))  &&
                    (urng_seed2 >= W'(8))  && (urng_seed5 >= W'(8))  &&
                    (urng_seed3 >= W'(16)) && (urng_seed6 >= W'(16));

  // stop has priority over start in IDLE
  assign go        = (state == IDLE) && start && !stop;
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  // Advance only when the sample can be kept; a pop frees the slot this edge
  assign urng_en   = !stop && ((state == WARM) ||
                     ((state == RUN) && ((fifo_cnt < 2'd2) || pop)));
  assign push      = urng_en && (state == RUN);
  assign out_a     = fa[rd_ptr];
  assign out_b     = fb[rd_ptr];

  // Sequencer: IDLE -> LOAD -> WARM (WARMUP cycles) -> RUN, stop aborts
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      warm_cnt <= 8'd0;
      urng_rst <= 1'b1;
      busy     <= 1'b0;
      seed_err <= 1'b0;
    end else if (stop && state != IDLE) begin
      state    <= IDLE;
      urng_rst <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          if (!seeds_ok) begin
            seed_err <= 1'b1;
          end else begin
            seed_err <= 1'b0;
            state    <= LOAD;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          state    <= WARM;
          warm_cnt <= 8'(WARMUP);
          urng_rst <= 1'b0;
        end
        WARM: begin
          if (warm_cnt == 8'd1) state <= RUN;
          else                  warm_cnt <= warm_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Seed registers, writable only while idle so a run never sees them move
  always_ff @(posedge clk) begin
    if (reset) begin
      urng_seed1 <= '0; urng_seed2 <= '0; urng_seed3 <= '0;
      urng_seed4 <= '0; urng_seed5 <= '0; urng_seed6 <= '0;
    end else if (cfg_wr && state == IDLE) begin
      case (cfg_addr)
        3'd0: urng_seed1 <= cfg_wdata;
        3'd1: urng_seed2 <= cfg_wdata;
        3'd2: urng_seed3 <= cfg_wdata;
        3'd3: urng_seed4 <= cfg_wdata;
        3'd4: urng_seed5 <= cfg_wdata;
        3'd5: urng_seed6 <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // Handshake counter, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (reset)                      sample_cnt <= 32'd0;
    else if (go && seeds_ok)        sample_cnt <= 32'd0;
    else if (pop)                   sample_cnt <= sample_cnt + 32'd1;
  end

  // 2-entry in-order buffer; a push at full only happens alongside a pop,
  // so it lands in the slot being vacated
  always_ff @(posedge clk) begin
    if (reset) begin
      fa[0] <= '0; fa[1] <= '0; fb[0] <= '0; fb[1] <= '0;
      wr_ptr <= 1'b0; rd_ptr <= 1'b0; fifo_cnt <= 2'd0;
    end else if (stop && state != IDLE) begin
      wr_ptr <= 1'b0; rd_ptr <= 1'b0; fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fa[wr_ptr] <= urng_a;
        fb[wr_ptr] <= urng_b;
        wr_ptr     <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: ;
      endcase
    end
  end

endmodule
